led_frame_sequencer: RTL and testbench

- Upstream feeder for the 2-wire LED-array byte serializer, which takes one byte per `valid` pulse and reports `busy` while shifting.
- Holds an 8-byte frame buffer (one byte per column of the 8x8 array) written by the host logic.
- On a refresh request, sends a fixed 11-byte frame as a series of single-byte handshakes: data command, address command, 8 column bytes, display-control byte.
- Provides frame-level status and an ack timeout toward the serializer.

---
 rtl/led_frame_sequencer.sv | 174 +++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_sequencer
// Purpose  : Streams an 11-byte LED frame (commands, 8 columns, display
//            control) to a byte serializer using a valid/busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_sequencer #(
    parameter int          ACK_TIMEOUT    = 64,
    parameter int          REFRESH_PERIOD = 0,
    parameter logic [7:0]  CMD_DATA       = 8'h40,
    parameter logic [7:0]  CMD_ADDR       = 8'hC0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       fb_we,
    input  logic [2:0] fb_addr,
    input  logic [7:0] fb_wdata,
    input  logic [2:0] brightness,
    input  logic       display_on,
    input  logic       refresh,
    output logic       tx_valid,
    output logic [7:0] tx_value,
    input  logic       tx_busy,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       error
);

    localparam int         c_ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [3:0] c_LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t             r_state;
    logic [7:0]         r_fb [8];
    logic [3:0]         r_index;
    logic [c_ACK_W-1:0] r_ack_cnt;
    logic               r_pending;
    logic [2:0]         r_bright_s;
    logic               r_disp_s;
    logic               w_tick;
    logic               w_start;
    logic [7:0]         w_byte;

    generate
        if (REFRESH_PERIOD > 0) begin : g_auto
            localparam int c_RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            logic [c_RW-1:0] r_auto_cnt;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_auto_cnt <= '0;
                end else if (r_auto_cnt == c_RW'(REFRESH_PERIOD - 1)) begin
                    r_auto_cnt <= '0;
                end else begin
                    r_auto_cnt <= r_auto_cnt + 1'b1;
                end
            end

            assign w_tick = (r_auto_cnt == c_RW'(REFRESH_PERIOD - 1));
        end else begin : g_no_auto
            assign w_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                r_fb[i] <= 8'h00;
            end
        end else if (fb_we) begin
            r_fb[fb_addr] <= fb_wdata;
        end
    end

    assign w_start = (r_state == S_IDLE) && r_pending;

    // A new request during the consuming cycle stays queued for the next frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= (r_pending && !w_start) || refresh || w_tick;
        end
    end

    always_comb begin
        w_byte = CMD_DATA;
        case (r_index)
            4'd0:       w_byte = CMD_DATA;
            4'd1:       w_byte = CMD_ADDR;
            c_LAST_IDX: w_byte = {4'b1000, r_disp_s, r_bright_s};
            default:    w_byte = r_fb[3'(r_index - 4'd2)];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_index    <= 4'd0;
            r_ack_cnt  <= '0;
            r_bright_s <= 3'd0;
            r_disp_s   <= 1'b0;
            tx_valid   <= 1'b0;
            tx_value   <= 8'h00;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_index    <= 4'd0;
                        r_bright_s <= brightness;
                        r_disp_s   <= display_on;
                        frame_busy <= 1'b1;
                        error      <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_valid  <= 1'b1;
                    tx_value  <= w_byte;
                    r_ack_cnt <= '0;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_ack_cnt == c_ACK_W'(ACK_TIMEOUT - 1)) begin
                        error      <= 1'b1;
                        frame_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_index == c_LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_index <= r_index + 4'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    frame_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_sequencer
// Purpose  : Directed self-checking bench for led_frame_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_frame_sequencer;

    logic       clk = 1'b0;
    logic       resetn, fb_we, display_on, refresh, tx_busy;
    logic [2:0] fb_addr, brightness;
    logic [7:0] fb_wdata, tx_value;
    logic       tx_valid, frame_busy, frame_done, error;

    logic       resetn_a, fb_we_a, display_on_a, refresh_a, tx_busy_a;
    logic [2:0] fb_addr_a, brightness_a;
    logic [7:0] fb_wdata_a, tx_value_a;
    logic       tx_valid_a, frame_busy_a, frame_done_a, error_a;

    int total = 0;
    int bad   = 0;
    bit ser_en;

    logic [7:0] vals[$];
    int vcyc[$], fcyc[$], rcyc[$], bcyc[$], dcyc[$], ecyc[$];
    int ndone = 0;
    int cyc = 0;
    logic prev_busy = 1'b0, prev_fb = 1'b0, prev_err = 1'b0;

    int avcyc[$];
    int acyc = 0;
    int adone = 0;
    int abusy_cnt = 0;

    always #5 clk = ~clk;

    led_frame_sequencer #(.ACK_TIMEOUT(64), .REFRESH_PERIOD(0)) dut (
        .clk(clk), .resetn(resetn), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .brightness(brightness), .display_on(display_on),
        .refresh(refresh), .tx_valid(tx_valid), .tx_value(tx_value),
        .tx_busy(tx_busy), .frame_busy(frame_busy), .frame_done(frame_done),
        .error(error)
    );

    led_frame_sequencer #(.ACK_TIMEOUT(64), .REFRESH_PERIOD(2000)) dut_a (
        .clk(clk), .resetn(resetn_a), .fb_we(fb_we_a), .fb_addr(fb_addr_a),
        .fb_wdata(fb_wdata_a), .brightness(brightness_a), .display_on(display_on_a),
        .refresh(refresh_a), .tx_valid(tx_valid_a), .tx_value(tx_value_a),
        .tx_busy(tx_busy_a), .frame_busy(frame_busy_a), .frame_done(frame_done_a),
        .error(error_a)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serializer: busy rises 20 cycles after a strobe and stays up 300 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_valid && ser_en) begin
                repeat (20) @(negedge clk);
                tx_busy = 1'b1;
                repeat (300) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_valid_a) abusy_cnt = 3;
        else if (abusy_cnt > 0) abusy_cnt--;
        tx_busy_a = (abusy_cnt != 0);
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_valid) begin
            vals.push_back(tx_value);
            vcyc.push_back(cyc);
        end
        if (prev_busy && !tx_busy) fcyc.push_back(cyc);
        if (refresh) rcyc.push_back(cyc);
        if (frame_busy && !prev_fb) bcyc.push_back(cyc);
        if (error && !prev_err) ecyc.push_back(cyc);
        if (frame_done) begin
            ndone++;
            dcyc.push_back(cyc);
        end
        prev_busy = tx_busy;
        prev_fb   = frame_busy;
        prev_err  = error;
        if (resetn_a) acyc++;
        if (tx_valid_a && tx_value_a == 8'h40) avcyc.push_back(acyc);
        if (frame_done_a) adone++;
    end

    task automatic clr();
        vals.delete(); vcyc.delete(); fcyc.delete(); rcyc.delete();
        bcyc.delete(); dcyc.delete(); ecyc.delete();
        ndone = 0;
    endtask

    task automatic fb_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        fb_we = 1'b1; fb_addr = a; fb_wdata = d;
        @(negedge clk);
        fb_we = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic wait_vals(input int n, input int maxc);
        int k = 0;
        while (vals.size() < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (vals.size() < n) chk("wait_vals_timeout", vals.size(), n);
    endtask

    task automatic wait_done(input int n, input int maxc);
        int k = 0;
        while (ndone < n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (ndone < n) chk("wait_done_timeout", ndone, n);
    endtask

    logic [7:0] exp1 [11] = '{8'h40, 8'hC0, 8'h01, 8'h02, 8'h04, 8'h08,
                              8'h10, 8'h20, 8'h40, 8'h80, 8'h8D};

    initial begin
        resetn = 1'b0; fb_we = 1'b0; fb_addr = 3'd0; fb_wdata = 8'h00;
        brightness = 3'd0; display_on = 1'b0; refresh = 1'b0; ser_en = 1'b1;
        resetn_a = 1'b0; fb_we_a = 1'b0; fb_addr_a = 3'd0; fb_wdata_a = 8'h00;
        brightness_a = 3'd0; display_on_a = 1'b0; refresh_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_value", tx_value, 0);
        chk("rst_frame_busy", frame_busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_error", error, 0);
        resetn = 1'b1; resetn_a = 1'b1;

        // Full frame with handshake latencies
        for (int i = 0; i < 8; i++) fb_write(3'(i), 8'h01 << i);
        brightness = 3'd5; display_on = 1'b1;
        repeat (2) @(negedge clk);
        clr();
        pulse_refresh();
        wait_done(1, 6000);
        repeat (5) @(negedge clk);
        chk("f1_count", vals.size(), 11);
        for (int i = 0; i < 11; i++) chk($sformatf("f1_byte%0d", i), vals[i], exp1[i]);
        chk("f1_done", ndone, 1);
        chk("f1_frame_busy", frame_busy, 0);
        chk("f1_error", error, 0);
        chk("f1_busy_lat", bcyc[0] - rcyc[0], 1);
        chk("f1_valid_lat", vcyc[0] - rcyc[0], 2);
        chk("f1_gap", vcyc[1] - fcyc[0], 2);

        // Ack timeout
        ser_en = 1'b0;
        clr();
        pulse_refresh();
        begin
            int k = 0;
            while (!error && k < 300) begin @(negedge clk); k++; end
        end
        repeat (5) @(negedge clk);
        chk("to_error", error, 1);
        chk("to_frame_busy", frame_busy, 0);
        chk("to_done", ndone, 0);
        chk("to_count", vals.size(), 1);
        chk("to_latency", ecyc[0] - vcyc[0], 64);
        ser_en = 1'b1;

        // Merged requests during a frame
        clr();
        pulse_refresh();
        wait_vals(2, 2000);
        pulse_refresh();
        wait_vals(5, 2000);
        pulse_refresh();
        wait_vals(9, 2000);
        pulse_refresh();
        wait_done(2, 9000);
        repeat (400) @(negedge clk);
        chk("mr_count", vals.size(), 22);
        chk("mr_done", ndone, 2);
        chk("mr_back2back", vcyc[11] - dcyc[0], 2);
        chk("mr_error_cleared", error, 0);
        chk("mr_frame_busy", frame_busy, 0);

        // Late column write and brightness snapshot
        clr();
        pulse_refresh();
        wait_vals(4, 2000);
        fb_write(3'd5, 8'hAA);
        brightness = 3'd1;
        wait_done(1, 6000);
        chk("sn_byte3", vals[3], 8'h02);
        chk("sn_byte7", vals[7], 8'hAA);
        chk("sn_byte10", vals[10], 8'h8D);
        brightness = 3'd5;
        repeat (5) @(negedge clk);

        // Reset mid-frame
        clr();
        pulse_refresh();
        wait_vals(7, 3000);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mr_rst_valid", tx_valid, 0);
        chk("mr_rst_value", tx_value, 0);
        chk("mr_rst_frame_busy", frame_busy, 0);
        chk("mr_rst_frame_done", frame_done, 0);
        chk("mr_rst_error", error, 0);
        repeat (400) @(negedge clk);
        chk("mr_rst_no_valid", vals.size(), 7);
        clr();
        pulse_refresh();
        wait_done(1, 6000);
        chk("pr_count", vals.size(), 11);
        chk("pr_byte0", vals[0], 8'h40);
        for (int i = 2; i < 10; i++) chk($sformatf("pr_col%0d", i - 2), vals[i], 8'h00);
        chk("pr_byte10", vals[10], 8'h8D);

        // Auto refresh instance, running since reset release
        chk("ar_first", avcyc[0], 2002);
        chk("ar_second", avcyc[1], 4002);
        chk("ar_frames", (adone >= 2), 1);
        chk("ar_error", error_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
